// File: rtl/fpu_pkg.sv
// Shared FPU constants: rounding modes, fflag bit positions and canonical results.
package fpu_pkg;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
   localparam logic [30:0] MAX_FINITE = 31'h7F7F_FFFF;
   localparam logic [30:0] INF_MAG    = 31'h7F80_0000;

   // One accepted entry as held in the first pipeline register.
   typedef struct packed {
      logic        sign;
      logic [23:0] sig;    // hidden bit + 23-bit fraction, G/R/S already consumed
      logic [7:0]  expo;
      logic        of;
      logic        uf;
      logic        nan;
      logic        inf;
      logic        zero;
      logic        nv;
      logic        dz;
      logic [2:0]  rm;
      logic        inc;
      logic        nx;
   } s1_entry_t;

endpackage

// File: rtl/fpu_div_round_if.sv
// Handshake and data bundle between the divider normalizer, this rounder and the result mux.
interface fpu_div_round_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [26:0] in_sig;
   logic [7:0]  in_exp;
   logic        in_of;
   logic        in_uf;
   logic        in_nan;
   logic        in_inf;
   logic        in_zero;
   logic        in_nv;
   logic        in_dz;
   logic [2:0]  rm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  fflags;

   modport master (
      output in_valid, in_sign, in_sig, in_exp, in_of, in_uf, in_nan, in_inf,
             in_zero, in_nv, in_dz, rm, out_ready,
      input  in_ready, out_valid, result, fflags
   );

   modport slave (
      input  in_valid, in_sign, in_sig, in_exp, in_of, in_uf, in_nan, in_inf,
             in_zero, in_nv, in_dz, rm, out_ready,
      output in_ready, out_valid, result, fflags
   );
endinterface

// File: rtl/fpu_round_incr.sv
// Round-up decision and inexact flag from sign, mode and the L/G/R/S bits.
module fpu_round_incr
   import fpu_pkg::*;
(
   input  logic       sign,
   input  logic [2:0] rm,
   input  logic       l,
   input  logic       g,
   input  logic       r,
   input  logic       s,
   output logic       inc,
   output logic       nx
);

   // Mode-dependent increment; reserved modes fall back to round-to-nearest-even.
   always_comb begin
      nx = g | r | s;
      case (rm)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & nx;
         RM_RUP:  inc = ~sign & nx;
         RM_RMM:  inc = g;
         default: inc = g & (l | r | s);
      endcase
   end

endmodule

// File: rtl/fpu_div_round.sv
// Divider round-and-pack: two-stage valid/ready pipeline producing binary32 + fflags.
module fpu_div_round
   import fpu_pkg::*;
(
   input logic            clk,
   input logic            reset,
   input logic            flush,
   fpu_div_round_if.slave bus
);

   s1_entry_t   entry_p0;
   s1_entry_t   entry_p1;
   logic        inc_p0;
   logic        nx_p0;
   logic        vld_p1;
   logic        vld_p2;
   logic [31:0] result_p2;
   logic [4:0]  fflags_p2;
   logic        adv_p2;
   logic        accept_p0;

   // Magnitude delivered on overflow: infinity or the largest finite, by mode and sign.
   function automatic logic [30:0] ovf_mag(input logic sign, input logic [2:0] rm);
      case (rm)
         RM_RTZ:  ovf_mag = MAX_FINITE;
         RM_RDN:  ovf_mag = sign ? INF_MAG : MAX_FINITE;
         RM_RUP:  ovf_mag = sign ? MAX_FINITE : INF_MAG;
         default: ovf_mag = INF_MAG;
      endcase
   endfunction

   // Apply the increment, detect overflow and pack result with its flags.
   function automatic logic [36:0] pack_entry(input s1_entry_t e);
      logic [24:0] m25;
      logic [8:0]  exp9;
      logic        ovf;
      logic [31:0] res;
      logic [4:0]  fl;
      m25 = {1'b0, e.sig} + {24'd0, e.inc};
      // Subnormals promote through m25[23]; normals bump on carry out of the hidden bit.
      if (e.expo == 8'd0) exp9 = {1'b0, e.expo} + {8'd0, m25[23]};
      else                exp9 = {1'b0, e.expo} + {8'd0, m25[24]};
      ovf = e.of | (exp9 >= 9'd255);
      res = 32'd0;
      fl  = 5'd0;
      if (e.nan) begin
         res         = CANON_NAN;
         fl[FLAG_NV] = e.nv;
      end else if (e.inf) begin
         res         = {e.sign, INF_MAG};
         fl[FLAG_DZ] = e.dz;
      end else if (e.zero) begin
         res = {e.sign, 31'd0};
      end else if (ovf) begin
         res         = {e.sign, ovf_mag(e.sign, e.rm)};
         fl[FLAG_OF] = 1'b1;
         fl[FLAG_NX] = 1'b1;
      end else begin
         res         = {e.sign, exp9[7:0], m25[22:0]};
         fl[FLAG_UF] = (e.uf | (e.expo == 8'd0)) & e.nx;
         fl[FLAG_NX] = e.nx;
      end
      return {res, fl};
   endfunction

   fpu_round_incr u_incr (
      .sign (bus.in_sign),
      .rm   (bus.rm),
      .l    (bus.in_sig[3]),
      .g    (bus.in_sig[2]),
      .r    (bus.in_sig[1]),
      .s    (bus.in_sig[0]),
      .inc  (inc_p0),
      .nx   (nx_p0)
   );

   assign adv_p2       = ~vld_p2 | bus.out_ready;
   assign bus.in_ready = ~vld_p1 | adv_p2;
   assign accept_p0    = bus.in_valid & bus.in_ready;

   assign entry_p0 = '{
      sign: bus.in_sign, sig: bus.in_sig[26:3], expo: bus.in_exp,
      of: bus.in_of, uf: bus.in_uf, nan: bus.in_nan, inf: bus.in_inf,
      zero: bus.in_zero, nv: bus.in_nv, dz: bus.in_dz, rm: bus.rm,
      inc: inc_p0, nx: nx_p0
   };

   // Stage valids: reset or flush kill everything, including a same-cycle input.
   always_ff @(posedge clk) begin
      if (reset | flush) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (bus.in_ready) vld_p1 <= bus.in_valid;
         if (adv_p2)       vld_p2 <= vld_p1;
      end
   end

   // ---- stage 1: capture entry with its rounding decision ----
   always_ff @(posedge clk) begin
      if (accept_p0) entry_p1 <= entry_p0;
   end

   // ---- stage 2: packed result, held while the consumer stalls ----
   always_ff @(posedge clk) begin
      if (reset) begin
         result_p2 <= 32'd0;
         fflags_p2 <= 5'd0;
      end else if (adv_p2 & vld_p1) begin
         {result_p2, fflags_p2} <= pack_entry(entry_p1);
      end
   end

   assign bus.out_valid = vld_p2;
   assign bus.result    = result_p2;
   assign bus.fflags    = fflags_p2;

endmodule

// File: tb/tb_fpu_div_round.sv
// Directed-vector bench for the divider round-and-pack stage.
module tb_fpu_div_round;
   import fpu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   fpu_div_round_if bus ();

   fpu_div_round dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sign;
      logic [26:0] sig;
      logic [7:0]  expo;
      logic [2:0]  rm;
      logic        of;
      logic        uf;
      logic        nan;
      logic        inf;
      logic        zero;
      logic        nv;
      logic        dz;
      logic [31:0] exp_res;
      logic [4:0]  exp_fl;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   int n_tests = 0;
   int n_fail  = 0;

   logic        mon_en = 1'b0;
   logic [31:0] mon_q [$];

   // Records every output transfer while enabled.
   always @(negedge clk) begin
      #1;
      if (mon_en && bus.out_valid && bus.out_ready) mon_q.push_back(bus.result);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic sign, input logic [26:0] sig, input logic [7:0] expo,
                               input logic [2:0] rm, input logic [6:0] sel,
                               input logic [31:0] r, input logic [4:0] f);
      vec_t v;
      v.sign = sign; v.sig = sig; v.expo = expo; v.rm = rm;
      {v.of, v.uf, v.nan, v.inf, v.zero, v.nv, v.dz} = sel;
      v.exp_res = r; v.exp_fl = f;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.in_valid = 1'b1;
      bus.in_sign  = v.sign;
      bus.in_sig   = v.sig;
      bus.in_exp   = v.expo;
      bus.rm       = v.rm;
      {bus.in_of, bus.in_uf, bus.in_nan, bus.in_inf, bus.in_zero, bus.in_nv, bus.in_dz} =
         {v.of, v.uf, v.nan, v.inf, v.zero, v.nv, v.dz};
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_sign  = 1'b0;
      bus.in_sig   = 27'd0;
      bus.in_exp   = 8'd0;
      bus.rm       = RM_RNE;
      {bus.in_of, bus.in_uf, bus.in_nan, bus.in_inf, bus.in_zero, bus.in_nv, bus.in_dz} = 7'd0;
   endtask

   initial begin
      // sel bits: {of, uf, nan, inf, zero, nv, dz}
      vecs[0]  = mk(0, 27'h4000000, 8'd127, RM_RNE, 7'b0000000, 32'h3F800000, 5'h00);
      vecs[1]  = mk(0, 27'h4000004, 8'd127, RM_RNE, 7'b0000000, 32'h3F800000, 5'h01);
      vecs[2]  = mk(0, 27'h400000C, 8'd127, RM_RNE, 7'b0000000, 32'h3F800002, 5'h01);
      vecs[3]  = mk(0, 27'h7FFFFFC, 8'd127, RM_RNE, 7'b0000000, 32'h40000000, 5'h01);
      vecs[4]  = mk(0, 27'h7FFFFFC, 8'd254, RM_RNE, 7'b0000000, 32'h7F800000, 5'h05);
      vecs[5]  = mk(0, 27'h7FFFFFC, 8'd254, RM_RTZ, 7'b0000000, 32'h7F7FFFFF, 5'h01);
      vecs[6]  = mk(0, 27'h7FFFFFC, 8'd254, RM_RDN, 7'b0000000, 32'h7F7FFFFF, 5'h01);
      vecs[7]  = mk(0, 27'h7FFFFFC, 8'd254, RM_RDN, 7'b1000000, 32'h7F7FFFFF, 5'h05);
      vecs[8]  = mk(1, 27'h7FFFFFC, 8'd254, RM_RDN, 7'b0000000, 32'hFF800000, 5'h05);
      vecs[9]  = mk(1, 27'h4000000, 8'd254, RM_RUP, 7'b1000000, 32'hFF7FFFFF, 5'h05);
      vecs[10] = mk(0, 27'h0000000, 8'd0,   RM_RNE, 7'b0010010, 32'h7FC00000, 5'h10);
      vecs[11] = mk(1, 27'h0000000, 8'd0,   RM_RNE, 7'b0001001, 32'hFF800000, 5'h08);
      vecs[12] = mk(0, 27'h0000004, 8'd0,   RM_RUP, 7'b0000000, 32'h00000001, 5'h03);
      vecs[13] = mk(0, 27'h3FFFFFC, 8'd0,   RM_RNE, 7'b0000000, 32'h00800000, 5'h03);
      vecs[14] = mk(1, 27'h4000007, 8'd127, RM_RNE, 7'b0000100, 32'h80000000, 5'h00);
      vecs[15] = mk(1, 27'h0000000, 8'd0,   RM_RNE, 7'b0011000, 32'h7FC00000, 5'h00);
      vecs[16] = mk(0, 27'h4000004, 8'd127, RM_RMM, 7'b0000000, 32'h3F800001, 5'h01);
      vecs[17] = mk(0, 27'h400000C, 8'd127, 3'd7,   7'b0000000, 32'h3F800002, 5'h01);

      idle();
      flush         = 1'b0;
      bus.out_ready = 1'b1;
      reset         = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_fflags", {27'd0, bus.fflags}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Table-driven vectors, one at a time with latency check.
      for (int i = 0; i < NVEC; i++) begin
         int cyc;
         drive(vecs[i]);
         check($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
         @(negedge clk);
         idle();
         cyc = 1;
         while (!bus.out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
         end
         check($sformatf("vec%0d_latency", i), cyc, 32'd2);
         check($sformatf("vec%0d_result", i), bus.result, vecs[i].exp_res);
         check($sformatf("vec%0d_fflags", i), {27'd0, bus.fflags}, {27'd0, vecs[i].exp_fl});
         @(negedge clk);
      end

      // Backpressure: three offers with the consumer stalled, then drain.
      bus.out_ready = 1'b0;
      mon_q.delete();
      mon_en = 1'b1;
      @(negedge clk);
      drive(vecs[0]);
      @(negedge clk);
      drive(vecs[3]);
      check("bp_second_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      drive(vecs[2]);
      check("bp_third_stall", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      check("bp_still_stall", {31'd0, bus.in_ready}, 32'd0);
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_hold_result", bus.result, 32'h3F800000);
      bus.out_ready = 1'b1;
      @(negedge clk);
      idle();
      repeat (6) @(negedge clk);
      mon_en = 1'b0;
      check("bp_count", mon_q.size(), 32'd3);
      if (mon_q.size() == 3) begin
         check("bp_order0", mon_q[0], 32'h3F800000);
         check("bp_order1", mon_q[1], 32'h40000000);
         check("bp_order2", mon_q[2], 32'h3F800002);
      end

      // Flush with two entries in flight and a third offered in the flush cycle.
      bus.out_ready = 1'b0;
      @(negedge clk);
      drive(vecs[0]);
      @(negedge clk);
      drive(vecs[2]);
      @(negedge clk);
      drive(vecs[3]);
      flush = 1'b1;
      check("fl_pre_valid", {31'd0, bus.out_valid}, 32'd1);
      @(negedge clk);
      flush = 1'b0;
      idle();
      check("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.out_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("fl_no_revive", {31'd0, bus.out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
